// File: rtl/mac_sequencer_if.sv
// Operand-pair stream and result handshake between a pair source, the MAC sequencer
// and a result sink. The slave modport is the sequencer's view.
interface mac_sequencer_if #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4
);
    localparam int unsigned CW = $clog2(K + 1);

    logic          s_valid;
    logic          s_ready;
    logic [N-1:0]  s_weight;
    logic [N-1:0]  s_in;
    logic          s_last;
    logic          abort;
    logic          r_valid;
    logic          r_ready;
    logic [N-1:0]  r_data;
    logic [CW-1:0] r_count;

    modport master (
        output s_valid, s_weight, s_in, s_last, abort, r_ready,
        input  s_ready, r_valid, r_data, r_count
    );

    modport slave (
        input  s_valid, s_weight, s_in, s_last, abort, r_ready,
        output s_ready, r_valid, r_data, r_count
    );
endinterface

// File: rtl/mac_sequencer.sv
// Feeds operand pairs into an external MAC core one dot product at a time, reads the
// accumulated result back after READ_LAT cycles and hands it out with its pair count.
module mac_sequencer #(
    parameter int unsigned N        = 8,
    parameter int unsigned K        = 4,
    parameter int unsigned READ_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    mac_sequencer_if.slave bus,
    output logic [N-1:0]   mac_weight,
    output logic [N-1:0]   mac_in,
    output logic           mac_reset,
    output logic           mac_oe,
    output logic           mac_forget,
    input  logic [N-1:0]   mac_out,
    output logic           err_len
);
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned RW = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {StClear, StAccum, StDrain, StRead, StHold} state_e;

    state_e        state;
    logic [CW-1:0] count;
    logic [RW-1:0] rd_cnt;
    logic          accept;
    logic          last_beat;

    assign mac_forget = 1'b0;
    assign accept     = bus.s_valid && bus.s_ready;
    assign last_beat  = bus.s_last || (count == CW'(K - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StClear;
            count       <= '0;
            rd_cnt      <= '0;
            bus.s_ready <= 1'b0;
            bus.r_valid <= 1'b0;
            bus.r_data  <= '0;
            bus.r_count <= '0;
            mac_weight  <= '0;
            mac_in      <= '0;
            mac_reset   <= 1'b1;
            mac_oe      <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            // Operands are zero unless a beat was accepted on this edge, so idle cycles add 0.
            mac_weight <= '0;
            mac_in     <= '0;
            if (bus.abort && (state inside {StAccum, StDrain, StRead})) begin
                // A beat accepted alongside abort is consumed and dropped.
                state       <= StClear;
                count       <= '0;
                bus.s_ready <= 1'b0;
                mac_oe      <= 1'b0;
                mac_reset   <= 1'b1;
            end else begin
                unique case (state)
                    StClear: begin
                        state       <= StAccum;
                        count       <= '0;
                        mac_reset   <= 1'b0;
                        bus.s_ready <= 1'b1;
                    end
                    StAccum: begin
                        if (accept) begin
                            mac_weight <= bus.s_weight;
                            mac_in     <= bus.s_in;
                            count      <= count + CW'(1);
                            if (last_beat) begin
                                state       <= StDrain;
                                bus.s_ready <= 1'b0;
                                if (!bus.s_last) err_len <= 1'b1;
                            end
                        end
                    end
                    StDrain: begin
                        state  <= StRead;
                        rd_cnt <= '0;
                        mac_oe <= 1'b1;
                    end
                    StRead: begin
                        if (rd_cnt == RW'(READ_LAT - 1)) begin
                            state       <= StHold;
                            mac_oe      <= 1'b0;
                            bus.r_valid <= 1'b1;
                            bus.r_data  <= mac_out;
                            bus.r_count <= count;
                        end else begin
                            rd_cnt <= rd_cnt + RW'(1);
                        end
                    end
                    StHold: begin
                        if (bus.r_ready) begin
                            state       <= StClear;
                            count       <= '0;
                            bus.r_valid <= 1'b0;
                            mac_reset   <= 1'b1;
                        end
                    end
                    default: state <= StClear;
                endcase
            end
        end
    end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter N, default 8: operand/result width, matching the MAC core N.
REQ-002 SHALL have parameter K, default 4: maximum pairs per dot product.
REQ-003 SHALL have parameter READ_LAT, default 1: cycles from mac_oe assertion to a valid mac_out.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset; no other clock and no other reset.
REQ-006 SHALL have port s_valid  input  1 / s_ready  output  1: operand-pair handshake.
REQ-007 SHALL have port s_weight  input  N / s_in  input  N / s_last  input  1: pair payload and final-pair marker.
REQ-008 SHALL have port abort  input  1: synchronous request to discard the current dot product.
REQ-009 SHALL have port mac_weight  output  N / mac_in  output  N: registered operands to the MAC core.
REQ-010 SHALL have port mac_reset  output  1 (active-high accumulator clear) / mac_oe  output  1 / mac_forget  output  1.
REQ-011 SHALL have port mac_out  input  N: MAC core result.
REQ-012 SHALL have port r_valid  output  1 / r_ready  input  1 / r_data  output  N / r_count  output  clog2(K+1): result handshake and pair count.
REQ-013 SHALL have port err_len  output  1: sticky flag set when K pairs arrive without s_last.

Function
REQ-014 SHALL implement states CLEAR, ACCUM, DRAIN, READ, HOLD.
REQ-015 CLEAR SHALL last exactly one cycle with mac_reset=1, s_ready=0, and pair count zeroed, then go to ACCUM.
REQ-016 ACCUM SHALL hold s_ready=1; a beat is accepted when s_valid&&s_ready.
REQ-017 SHALL drive mac_weight/mac_in with the accepted pair in the cycle after acceptance, and 0/0 in every other cycle, so idle cycles add zero to the accumulator.
REQ-018 SHALL increment the pair count on every accepted beat.
REQ-019 An accepted beat with s_last=1, or the K-th accepted beat, SHALL end ACCUM and move to DRAIN.
REQ-020 If the K-th beat has s_last=0, err_len SHALL be set; err_len clears only on reset.
REQ-021 DRAIN SHALL last one cycle, s_ready=0, presenting the final registered pair to the core.
REQ-022 READ SHALL assert mac_oe for READ_LAT cycles.
REQ-023 On the last READ cycle, mac_out SHALL be captured into r_data and the pair count into r_count; the next state is HOLD.
REQ-024 mac_oe SHALL be 0 outside READ, and mac_forget SHALL be held 0 at all times.
REQ-025 HOLD SHALL assert r_valid with r_data/r_count stable until r_ready=1, then go to CLEAR.
REQ-026 A HOLD cycle with r_ready=1 SHALL be followed by a CLEAR cycle, giving a minimum of one CLEAR cycle between results.
REQ-027 s_ready SHALL be 0 in every state except ACCUM; no beat is lost or duplicated.
REQ-028 abort=1 in ACCUM, DRAIN or READ SHALL force the next state to CLEAR, discard the count and produce no r_valid.
REQ-029 abort SHALL be ignored in HOLD and CLEAR.
REQ-030 abort and an accepted beat in the same cycle: abort SHALL win, and the beat is consumed and discarded.
REQ-031 The first pair SHALL be accumulated no earlier than the cycle after CLEAR.
REQ-032 Ideal latency, with pairs back-to-back and r_ready=1: last beat accepted at cycle t, r_valid at t+2+READ_LAT.

Reset
REQ-033 While reset=0, state SHALL be CLEAR and the following outputs SHALL be 0: s_ready, r_valid, r_data, r_count, mac_weight, mac_in, mac_oe, mac_forget, err_len.
REQ-034 While reset=0, mac_reset SHALL be 1.
REQ-035 On reset release, one CLEAR cycle SHALL occur before s_ready rises.
REQ-036 Reset asserted mid-operation SHALL abandon any dot product immediately, with no r_valid.

Verification
REQ-037 Pairs (2,2),(2,2),(2,2) with last on the third, core model behind it -> r_data=12, r_count=3, r_valid at t+3 with READ_LAT=1.
REQ-038 Pairs (2,2),(-2,2),(-2,2) -> r_data=0xFC (-4), r_count=3.
REQ-039 Gaps of 2 idle s_valid cycles between pairs (3,1),(1,1) -> mac_weight/mac_in=0 in gap cycles; r_data=4.
REQ-040 Four pairs (1,1) with s_last never set, K=4 -> r_data=4, r_count=4, err_len=1 and it stays 1 over later results.
REQ-041 abort on the cycle the second of three beats is accepted -> no r_valid, CLEAR cycle, next vector (5,1) with last -> r_data=5, r_count=1.
REQ-042 r_ready held 0 for 5 cycles in HOLD -> r_valid and r_data stable and s_ready=0 for those cycles; reset=0 pulse in READ -> all outputs per REQ-033/REQ-034.
